// File: rtl/lfsr_pkg.sv
// Shared LFSR constants: maximal-length Fibonacci tap masks and the
// operation encoding used by the LFSR core.
package lfsr_pkg;

    // Operation selected by the core on each clock.
    typedef enum logic [1:0] {
        CORE_HOLD    = 2'd0,
        CORE_STEP    = 2'd1,
        CORE_RECOVER = 2'd2,
        CORE_LOAD    = 2'd3
    } core_op_e;

    localparam int unsigned LFSR_MIN_WIDTH = 3;
    localparam int unsigned LFSR_MAX_WIDTH = 64;

    // Maximal-length taps, bit i set => state[i] enters the XOR.
    localparam logic [63:0] TAPS_W3  = 64'h0000_0000_0000_0006;
    localparam logic [63:0] TAPS_W4  = 64'h0000_0000_0000_000C;
    localparam logic [63:0] TAPS_W5  = 64'h0000_0000_0000_0014;
    localparam logic [63:0] TAPS_W6  = 64'h0000_0000_0000_0030;
    localparam logic [63:0] TAPS_W7  = 64'h0000_0000_0000_0060;
    localparam logic [63:0] TAPS_W8  = 64'h0000_0000_0000_00B8;
    localparam logic [63:0] TAPS_W9  = 64'h0000_0000_0000_0110;
    localparam logic [63:0] TAPS_W10 = 64'h0000_0000_0000_0240;
    localparam logic [63:0] TAPS_W11 = 64'h0000_0000_0000_0500;
    localparam logic [63:0] TAPS_W12 = 64'h0000_0000_0000_0829;
    localparam logic [63:0] TAPS_W13 = 64'h0000_0000_0000_100D;
    localparam logic [63:0] TAPS_W14 = 64'h0000_0000_0000_2015;
    localparam logic [63:0] TAPS_W15 = 64'h0000_0000_0000_6000;
    localparam logic [63:0] TAPS_W16 = 64'h0000_0000_0000_D008;
    localparam logic [63:0] TAPS_W17 = 64'h0000_0000_0001_2000;
    localparam logic [63:0] TAPS_W18 = 64'h0000_0000_0002_0400;
    localparam logic [63:0] TAPS_W19 = 64'h0000_0000_0004_0023;
    localparam logic [63:0] TAPS_W20 = 64'h0000_0000_0009_0000;
    localparam logic [63:0] TAPS_W21 = 64'h0000_0000_0014_0000;
    localparam logic [63:0] TAPS_W22 = 64'h0000_0000_0030_0000;
    localparam logic [63:0] TAPS_W23 = 64'h0000_0000_0042_0000;
    localparam logic [63:0] TAPS_W24 = 64'h0000_0000_00E1_0000;
    localparam logic [63:0] TAPS_W25 = 64'h0000_0000_0120_0000;
    localparam logic [63:0] TAPS_W26 = 64'h0000_0000_0200_0023;
    localparam logic [63:0] TAPS_W27 = 64'h0000_0000_0400_0013;
    localparam logic [63:0] TAPS_W28 = 64'h0000_0000_0900_0000;
    localparam logic [63:0] TAPS_W29 = 64'h0000_0000_1400_0000;
    localparam logic [63:0] TAPS_W30 = 64'h0000_0000_2000_0029;
    localparam logic [63:0] TAPS_W31 = 64'h0000_0000_4800_0000;
    localparam logic [63:0] TAPS_W32 = 64'h0000_0000_8020_0003;
    localparam logic [63:0] TAPS_W64 = 64'hD800_0000_0000_0000;

    // Default tap mask for a given register length; zero if no entry exists.
    function automatic logic [63:0] lfsr_taps(input int unsigned width);
        logic [63:0] t;
        t = '0;
        case (width)
            3:       t = TAPS_W3;
            4:       t = TAPS_W4;
            5:       t = TAPS_W5;
            6:       t = TAPS_W6;
            7:       t = TAPS_W7;
            8:       t = TAPS_W8;
            9:       t = TAPS_W9;
            10:      t = TAPS_W10;
            11:      t = TAPS_W11;
            12:      t = TAPS_W12;
            13:      t = TAPS_W13;
            14:      t = TAPS_W14;
            15:      t = TAPS_W15;
            16:      t = TAPS_W16;
            17:      t = TAPS_W17;
            18:      t = TAPS_W18;
            19:      t = TAPS_W19;
            20:      t = TAPS_W20;
            21:      t = TAPS_W21;
            22:      t = TAPS_W22;
            23:      t = TAPS_W23;
            24:      t = TAPS_W24;
            25:      t = TAPS_W25;
            26:      t = TAPS_W26;
            27:      t = TAPS_W27;
            28:      t = TAPS_W28;
            29:      t = TAPS_W29;
            30:      t = TAPS_W30;
            31:      t = TAPS_W31;
            32:      t = TAPS_W32;
            64:      t = TAPS_W64;
            default: t = '0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register: feedback XOR, load/step selection and recovery
// from the (illegal) all-zero state.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_taps(WIDTH)),
    parameter logic [WIDTH-1:0] INIT  = WIDTH'(1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output logic             fb
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    core_op_e         op;

    // Feedback bit: parity of the tapped state bits.
    always_comb begin
        fb = ^(state_q & TAPS);
    end

    // Pick the operation; a load wins, a step from zero becomes a recovery.
    always_comb begin
        if (load) begin
            op = CORE_LOAD;
        end else if (step && (state_q == '0)) begin
            op = CORE_RECOVER;
        end else if (step) begin
            op = CORE_STEP;
        end else begin
            op = CORE_HOLD;
        end
    end

    // Next state; a zero load value is replaced by INIT so the register never locks.
    always_comb begin
        state_d = state_q;
        unique case (op)
            CORE_LOAD:    state_d = (load_val == '0) ? INIT : load_val;
            CORE_RECOVER: state_d = INIT;
            CORE_STEP:    state_d = {state_q[WIDTH-2:0], fb};
            default:      state_d = state_q;
        endcase
    end

    // State register with synchronous reset to INIT.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/lfsr_prng_stream.sv
// LFSR pseudo-random word stream: packs OUT_BITS feedback bits per word and
// presents them on a valid/ready interface with a sticky zero-lockup flag.
module lfsr_prng_stream
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(lfsr_taps(WIDTH)),
    parameter int unsigned      OUT_BITS = 8,
    parameter logic [WIDTH-1:0] INIT     = WIDTH'(1)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                E,
    input  logic                SEED_LD,
    input  logic [WIDTH-1:0]    SEED,
    output logic [OUT_BITS-1:0] DOUT,
    output logic                DVALID,
    input  logic                DREADY,
    output logic [WIDTH-1:0]    STATE,
    output logic                LOCKUP
);

    localparam int unsigned      CNT_W    = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
    localparam int unsigned      COL_W    = (OUT_BITS > 1) ? OUT_BITS - 1 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_BITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [OUT_BITS-1:0] dout_q, dout_d;
    logic                dvalid_q, dvalid_d;
    logic                lockup_q, lockup_d;

    logic [WIDTH-1:0]    core_state;
    logic                core_fb;
    logic [OUT_BITS-1:0] word;
    logic                cnt_last;
    logic                step_en;
    logic                complete;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .INIT  (INIT)
    ) u_core (
        .CLK      (CLK),
        .RESET    (RESET),
        .step     (step_en),
        .load     (SEED_LD),
        .load_val (SEED),
        .state    (core_state),
        .fb       (core_fb)
    );

    // Step qualification: only the word-completing step stalls behind an unaccepted word.
    // The casts truncate {collector, fb} so OUT_BITS==1 needs no separate path.
    always_comb begin
        cnt_last = (cnt_q == CNT_LAST);
        step_en  = E && !SEED_LD && !(dvalid_q && !DREADY && cnt_last);
        complete = step_en && cnt_last;
        word     = OUT_BITS'({col_q, core_fb});
    end

    // Counter, collector, output word, handshake and lockup next-state.
    always_comb begin
        cnt_d    = cnt_q;
        col_d    = col_q;
        dout_d   = dout_q;
        dvalid_d = dvalid_q;
        lockup_d = lockup_q;
        if (SEED_LD) begin
            cnt_d    = '0;
            col_d    = '0;
            dvalid_d = 1'b0;
            lockup_d = (SEED == '0);
        end else begin
            if (step_en) begin
                if (cnt_last) begin
                    cnt_d  = '0;
                    col_d  = '0;
                    dout_d = word;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    col_d = COL_W'({col_q, core_fb});
                end
                if (core_state == '0) begin
                    lockup_d = 1'b1;
                end
            end
            if (complete) begin
                dvalid_d = 1'b1;
            end else if (dvalid_q && DREADY) begin
                dvalid_d = 1'b0;
            end
        end
    end

    // Stream registers; reset discards any partial word.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q    <= '0;
            col_q    <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            col_q    <= col_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            lockup_q <= lockup_d;
        end
    end

    assign DOUT   = dout_q;
    assign DVALID = dvalid_q;
    assign STATE  = core_state;
    assign LOCKUP = lockup_q;

endmodule
